// File: rtl/lfu_pkg.sv
// Shared sizing for the LFU replacement selector: default widths, derived sizes and
// the counter-array type.
package lfu_pkg;

  parameter int unsigned BUF_BIT_DEF = 2;
  parameter int unsigned CNT_BIT_DEF = 2;
  parameter int unsigned NUM_BUF_DEF = 2 ** BUF_BIT_DEF;
  parameter int unsigned CNT_MAX_DEF = (2 ** CNT_BIT_DEF) - 1;

  typedef logic [NUM_BUF_DEF-1:0][CNT_BIT_DEF-1:0] cnt_arr_t;

endpackage

// File: rtl/buf_rplc_handle.sv
// Combinational minimum finder: returns the index of the smallest access counter,
// lowest index on ties.
module buf_rplc_handle
  import lfu_pkg::*;
#(
  parameter int unsigned BUF_BIT = BUF_BIT_DEF,
  parameter int unsigned CNT_BIT = CNT_BIT_DEF,
  localparam int unsigned NUM_BUF = 2 ** BUF_BIT
) (
  input  logic [NUM_BUF-1:0][CNT_BIT-1:0] t_in,
  output logic [BUF_BIT-1:0]              rplc_buf_int
);

  logic [CNT_BIT-1:0] t_cmp;

  // Strict less-than keeps the earlier (lower) index when counts are equal.
  always_comb begin
    t_cmp        = t_in[0];
    rplc_buf_int = '0;
    for (int i = 1; i < NUM_BUF; i++) begin
      if (t_in[i] < t_cmp) begin
        t_cmp        = t_in[i];
        rplc_buf_int = BUF_BIT'(i);
      end
    end
  end

endmodule

// File: rtl/lfu_finder.sv
// Least-frequently-used replacement selector: per-buffer saturating access counters and
// a registered index of the least-referenced buffer.
module lfu_finder
  import lfu_pkg::*;
#(
  parameter int unsigned BUF_BIT = BUF_BIT_DEF,
  parameter int unsigned CNT_BIT = CNT_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_buf_req,
  input  logic [BUF_BIT-1:0] ref_buf_req,
  output logic [BUF_BIT-1:0] buf_num_replc
);

  localparam int unsigned        NUM_BUF = 2 ** BUF_BIT;
  localparam logic [CNT_BIT-1:0] CNT_MAX = '1;

  typedef logic [NUM_BUF-1:0][CNT_BIT-1:0] cnt_t;

  cnt_t               t_in;
  cnt_t               t_in_d;
  logic [BUF_BIT-1:0] rplc_buf_int;
  logic               max_flg;

  // The clear is applied after the increment so it wins when both hit the same slot.
  always_comb begin
    t_in_d = t_in;
    if (t_in[ref_buf_req] != CNT_MAX) begin
      t_in_d[ref_buf_req] = t_in[ref_buf_req] + 1'b1;
    end
    if (new_buf_req) begin
      t_in_d[buf_num_replc] = '0;
    end
  end

  always_comb begin
    max_flg = 1'b0;
    for (int i = 0; i < NUM_BUF; i++) begin
      max_flg = max_flg | (t_in[i] == CNT_MAX);
    end
  end

  buf_rplc_handle #(
    .BUF_BIT (BUF_BIT),
    .CNT_BIT (CNT_BIT)
  ) u_buf_rplc_handle (
    .t_in         (t_in),
    .rplc_buf_int (rplc_buf_int)
  );

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      t_in          <= '0;
      buf_num_replc <= '0;
    end else begin
      t_in          <= t_in_d;
      buf_num_replc <= rplc_buf_int;
    end
  end

endmodule

// File: tb/tb_lfu_finder.sv
// Directed bench for lfu_finder: each step applies one edge and checks counters,
// max flag and replacement index against hand-computed values.
module tb_lfu_finder;

  logic       clk;
  logic       rst_n;
  logic       new_buf_req;
  logic [1:0] ref_buf_req;
  logic [1:0] buf_num_replc;

  int checks;
  int errors;

  lfu_finder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_buf_req   (new_buf_req),
    .ref_buf_req   (ref_buf_req),
    .buf_num_replc (buf_num_replc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs sampled 1 time unit later.
  task automatic step(input logic rst, input logic nb, input logic [1:0] r);
    rst_n       = rst;
    new_buf_req = nb;
    ref_buf_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int e0, input int e1, input int e2,
                              input int e3, input int erep, input int emax);
    check($sformatf("%s.t0", tag), 32'(dut.t_in[0]), e0);
    check($sformatf("%s.t1", tag), 32'(dut.t_in[1]), e1);
    check($sformatf("%s.t2", tag), 32'(dut.t_in[2]), e2);
    check($sformatf("%s.t3", tag), 32'(dut.t_in[3]), e3);
    check($sformatf("%s.rep", tag), 32'(buf_num_replc), erep);
    check($sformatf("%s.max", tag), 32'(dut.max_flg), emax);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b1;
    new_buf_req = 1'b0;
    ref_buf_req = 2'd0;

    // Reset, then hold ref 0
    step(1, 0, 0);
    step(1, 0, 0);
    expect_state("rst", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_state("r0a", 1, 0, 0, 0, 0, 0);
    step(0, 0, 0); expect_state("r0b", 2, 0, 0, 0, 1, 0);
    step(0, 0, 0); expect_state("r0c", 3, 0, 0, 0, 1, 1);
    step(0, 0, 0); expect_state("r0d", 3, 0, 0, 0, 1, 1);

    // Sweep refs 1..3 to saturation
    step(0, 0, 1); expect_state("sw1a", 3, 1, 0, 0, 1, 1);
    step(0, 0, 1); expect_state("sw1b", 3, 2, 0, 0, 2, 1);
    step(0, 0, 1); expect_state("sw1c", 3, 3, 0, 0, 2, 1);
    step(0, 0, 2); expect_state("sw2a", 3, 3, 1, 0, 2, 1);
    step(0, 0, 2); expect_state("sw2b", 3, 3, 2, 0, 3, 1);
    step(0, 0, 2); expect_state("sw2c", 3, 3, 3, 0, 3, 1);
    step(0, 0, 3); expect_state("sw3a", 3, 3, 3, 1, 3, 1);
    step(0, 0, 3); expect_state("sw3b", 3, 3, 3, 2, 3, 1);
    step(0, 0, 3); expect_state("sw3c", 3, 3, 3, 3, 3, 1);
    step(0, 0, 3); expect_state("swend", 3, 3, 3, 3, 0, 1);

    // Tie at {2,2,2,2}, then push buffer 0 to 3
    step(1, 0, 0); expect_state("tie_rst", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 3); step(0, 0, 3);
    step(0, 0, 2); step(0, 0, 2);
    expect_state("tie2", 2, 2, 2, 2, 2, 0);
    step(0, 0, 0); expect_state("tie3", 3, 2, 2, 2, 0, 1);
    step(0, 0, 0); expect_state("tie4", 3, 2, 2, 2, 1, 1);

    // Replace lowest: {3,3,0,3}
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 3);
    expect_state("rpl", 3, 3, 0, 3, 2, 1);
    step(0, 1, 0); expect_state("rpl_nb0", 3, 3, 0, 3, 2, 1);
    step(0, 0, 2); expect_state("rpl_r2", 3, 3, 1, 3, 2, 1);
    step(0, 1, 2); expect_state("rpl_clrwin", 3, 3, 0, 3, 2, 1);
    step(0, 0, 2); step(0, 0, 2);
    expect_state("rpl_22", 3, 3, 2, 3, 2, 1);
    step(0, 1, 1); expect_state("rpl_clr2", 3, 3, 0, 3, 2, 1);

    // Reset mid-count from {2,1,0,0}
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    expect_state("mid", 2, 1, 0, 0, 1, 0);
    step(1, 0, 3); expect_state("mid_rst", 0, 0, 0, 0, 0, 0);
    step(0, 0, 3); expect_state("mid_resume", 0, 0, 0, 1, 0, 0);
    step(0, 0, 0); expect_state("mid_r0", 1, 0, 0, 1, 0, 0);
    step(0, 1, 3); expect_state("mid_nb_r3", 0, 0, 0, 2, 1, 0);

    // Saturation hold on buffer 3
    step(0, 0, 3); expect_state("sat", 0, 0, 0, 3, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3);
      expect_state($sformatf("sat_hold%0d", i), 0, 0, 0, 3, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
